// File: rtl/add_sub_arbiter.sv
// Round-robin front end for one shared combinational add/sub unit: two requesters
// compete for it, and the result comes back on a single response channel tagged by ID.
module add_sub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_s,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_s,
    output logic             req1_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_s,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_s_q, op_s_d;
    logic             op_id_q, op_id_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;

    logic grant0, grant1;

    always_comb begin
        // On a tie the requester that did not win last time goes first.
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);

        // ready is also held low while reset is asserted.
        req0_ready = rst_n && (state_q == IDLE) && grant0;
        req1_ready = rst_n && (state_q == IDLE) && grant1;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_s_d       = op_s_q;
        op_id_d      = op_id_q;
        res_d        = res_q;
        carry_d      = carry_q;

        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    op_a_d       = req1_ready ? req1_a : req0_a;
                    op_b_d       = req1_ready ? req1_b : req0_b;
                    op_s_d       = req1_ready ? req1_s : req0_s;
                    op_id_d      = req1_ready;
                    last_grant_d = req1_ready;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_result;
                carry_d = alu_carry;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_s_q       <= 1'b0;
            op_id_q      <= 1'b0;
            res_q        <= '0;
            carry_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_s_q       <= op_s_d;
            op_id_q      <= op_id_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
        end
    end

    // The shared unit sees only latched operands, never the live request inputs.
    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_s      = op_s_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = op_id_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Bench for add_sub_arbiter: directed scenarios followed by randomized traffic, all
// checked against a plain-arithmetic reference and a round-robin grant model.
module tb_add_sub_arbiter;

    localparam int WIDTH = 4;
    localparam int MOD   = 1 << WIDTH;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_s, req1_s;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic             alu_s;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_carry, busy;
    logic [WIDTH-1:0] rsp_result;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int exp_last = 1;
    int pend [2];
    int pa   [2];
    int pb   [2];
    int ps   [2];

    add_sub_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
        .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
        .alu_result(alu_result), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .busy(busy)
    );

    // Shared combinational add/sub unit attached to the controller.
    logic [WIDTH:0] alu_full;
    assign alu_full   = alu_s ? ({1'b0, alu_a} - {1'b0, alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
    assign alu_result = alu_full[WIDTH-1:0];
    assign alu_carry  = alu_full[WIDTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
        $fatal(1, "watchdog");
    end

    function automatic int ref_res(input int a, input int b, input int s);
        int r;
        r = (s != 0) ? (a - b) : (a + b);
        return (r + MOD) % MOD;
    endfunction

    function automatic int ref_carry(input int a, input int b, input int s);
        if (s != 0) return (a < b) ? 1 : 0;
        return (a + b >= MOD) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input int v, input int a, input int b, input int s);
        if (id == 0) begin
            req0_valid = v[0]; req0_a = a[WIDTH-1:0]; req0_b = b[WIDTH-1:0]; req0_s = s[0];
        end else begin
            req1_valid = v[0]; req1_a = a[WIDTH-1:0]; req1_b = b[WIDTH-1:0]; req1_s = s[0];
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"},  32'(rsp_valid),  0);
        check({tag, "_rsp_id"},     32'(rsp_id),     0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 0);
        check({tag, "_rsp_carry"},  32'(rsp_carry),  0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_alu_a"},      32'(alu_a),      0);
        check({tag, "_alu_b"},      32'(alu_b),      0);
        check({tag, "_alu_s"},      32'(alu_s),      0);
        check({tag, "_ready0"},     32'(req0_ready), 0);
        check({tag, "_ready1"},     32'(req1_ready), 0);
    endtask

    // One requester alone, rsp_ready held high.
    task automatic single_op(input string tag, input int id, input int a, input int b, input int s);
        drive(id, 1, a, b, s);
        #1;
        check({tag, "_ready_win"},  32'(id == 0 ? req0_ready : req1_ready), 1);
        check({tag, "_ready_lose"}, 32'(id == 0 ? req1_ready : req0_ready), 0);
        tick();
        drive(id, 0, a, b, s);
        exp_last = id;
        check({tag, "_exec_busy"},  32'(busy),      1);
        check({tag, "_exec_rspv"},  32'(rsp_valid), 0);
        check({tag, "_alu_a"},      32'(alu_a),     a);
        check({tag, "_alu_b"},      32'(alu_b),     b);
        check({tag, "_alu_s"},      32'(alu_s),     s);
        tick();
        check({tag, "_rsp_valid"},  32'(rsp_valid),  1);
        check({tag, "_rsp_id"},     32'(rsp_id),     id);
        check({tag, "_rsp_result"}, 32'(rsp_result), ref_res(a, b, s));
        check({tag, "_rsp_carry"},  32'(rsp_carry),  ref_carry(a, b, s));
        tick();
        check({tag, "_idle_busy"},  32'(busy),      0);
        check({tag, "_idle_rspv"},  32'(rsp_valid), 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_last = 1;
        tick();
    endtask

    initial begin
        int w, bp, ea, eb, es, eres, ecar;

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive(0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
        drive(1, 1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
        repeat (3) tick();
        check_reset_outputs("reset_hold");
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        rst_n = 1'b1;
        exp_last = 1;
        tick();

        single_op("add_9_8", 0, 9, 8, 0);
        single_op("sub_3_5", 1, 3, 5, 1);
        single_op("sub_6_2", 1, 6, 2, 1);

        // Contention from reset: both held valid, grants must alternate 0,1,0,1.
        pulse_reset();
        drive(0, 1, 7, 1, 0);
        drive(1, 1, 6, 2, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            w = (exp_last == 0) ? 1 : 0;
            check("cont_ready0", 32'(req0_ready), 32'(w == 0));
            check("cont_ready1", 32'(req1_ready), 32'(w == 1));
            tick();
            exp_last = w;
            check("cont_exec_ready", 32'(req0_ready | req1_ready), 0);
            tick();
            ea = (w == 0) ? 7 : 6;
            eb = (w == 0) ? 1 : 2;
            es = w;
            check("cont_rsp_id",     32'(rsp_id),     w);
            check("cont_rsp_result", 32'(rsp_result), ref_res(ea, eb, es));
            check("cont_rsp_carry",  32'(rsp_carry),  ref_carry(ea, eb, es));
            tick();
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();

        // Backpressure with the other requester waiting.
        drive(0, 1, 5, 4, 0);
        #1;
        check("bp_ready0", 32'(req0_ready), 1);
        tick();
        exp_last = 0;
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 2, 9, 1);
        rsp_ready = 1'b0;
        tick();
        repeat (3) begin
            check("bp_rsp_valid",  32'(rsp_valid),  1);
            check("bp_rsp_result", 32'(rsp_result), 9);
            check("bp_rsp_carry",  32'(rsp_carry),  0);
            check("bp_rsp_id",     32'(rsp_id),     0);
            check("bp_busy",       32'(busy),       1);
            check("bp_ready",      32'({req0_ready, req1_ready}), 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_done_busy",   32'(busy),       0);
        check("bp_done_ready1", 32'(req1_ready), 1);
        // Requester 1 withdraws before any edge: no acceptance, pointer untouched.
        drive(1, 0, 2, 9, 1);
        tick();
        check("withdraw_busy", 32'(busy), 0);
        drive(0, 1, 1, 1, 0);
        drive(1, 1, 1, 1, 1);
        #1;
        check("withdraw_ptr_ready1", 32'(req1_ready), 1);
        check("withdraw_ptr_ready0", 32'(req0_ready), 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();

        // Reset while an operation is in EXEC.
        drive(0, 1, 9, 8, 0);
        #1;
        tick();
        drive(0, 0, 0, 0, 0);
        check("midrst_exec_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        exp_last = 1;
        repeat (4) begin
            tick();
            check("midrst_no_stale", 32'(rsp_valid | busy), 0);
        end
        single_op("add_15_1", 0, 15, 1, 0);

        // Randomized traffic with persistent pending requests and random backpressure.
        pend[0] = 0;
        pend[1] = 0;
        for (int it = 0; it < 60; it++) begin
            for (int r = 0; r < 2; r++) begin
                if (pend[r] == 0 && $urandom_range(0, 2) != 0) begin
                    pend[r] = 1;
                    pa[r] = $urandom_range(0, MOD - 1);
                    pb[r] = $urandom_range(0, MOD - 1);
                    ps[r] = $urandom_range(0, 1);
                end
                drive(r, pend[r], pa[r], pb[r], ps[r]);
            end
            #1;
            if (pend[0] != 0 && pend[1] != 0) w = (exp_last == 0) ? 1 : 0;
            else if (pend[0] != 0)            w = 0;
            else if (pend[1] != 0)            w = 1;
            else                              w = -1;
            check("rnd_ready0", 32'(req0_ready), 32'(w == 0));
            check("rnd_ready1", 32'(req1_ready), 32'(w == 1));
            if (w < 0) begin
                tick();
                continue;
            end
            tick();
            pend[w] = 0;
            exp_last = w;
            drive(w, 0, pa[w], pb[w], ps[w]);
            eres = ref_res(pa[w], pb[w], ps[w]);
            ecar = ref_carry(pa[w], pb[w], ps[w]);
            bp = $urandom_range(0, 2);
            rsp_ready = (bp == 0);
            tick();
            repeat (bp) begin
                check("rnd_bp_valid", 32'(rsp_valid), 1);
                check("rnd_bp_ready", 32'({req0_ready, req1_ready}), 0);
                check("rnd_bp_result", 32'(rsp_result), eres);
                tick();
            end
            rsp_ready = 1'b1;
            check("rnd_rsp_valid",  32'(rsp_valid),  1);
            check("rnd_rsp_id",     32'(rsp_id),     w);
            check("rnd_rsp_result", 32'(rsp_result), eres);
            check("rnd_rsp_carry",  32'(rsp_carry),  ecar);
            tick();
            check("rnd_idle_busy", 32'(busy), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
